// File: rtl/count_seq_monitor.sv
// Sequence monitor for the mod-N phase counter: checks 0..N-1 wrap order,
// acquires/drops lock, and reports terminal-count pulses and error statistics.
module count_seq_monitor #(
    parameter int unsigned MODULUS     = 5,
    parameter int unsigned CW          = 3,
    parameter int unsigned LOCK_WRAPS  = 2,
    parameter int unsigned UNLOCK_ERRS = 3,
    parameter int unsigned WRAPW       = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [CW-1:0]    q_in,
    output logic             locked,
    output logic             seq_err,
    output logic             tc,
    output logic [WRAPW-1:0] wrap_cnt,
    output logic [7:0]       err_cnt,
    output logic [1:0]       state
);

    localparam logic [1:0] IDLE = 2'b00;
    localparam logic [1:0] ACQ  = 2'b01;
    localparam logic [1:0] LOCK = 2'b10;

    localparam int unsigned GW = $clog2(LOCK_WRAPS + 1);
    localparam int unsigned BW = $clog2(UNLOCK_ERRS + 1);

    logic [CW-1:0] prev;
    logic          prev_valid;
    logic [GW-1:0] good_wraps;
    logic [BW-1:0] bad_run;

    logic          prev_ok;
    logic [CW-1:0] expect_q;
    logic          legal;
    logic          wrap;
    logic          hold0;
    logic          illegal;
    logic          gw_hit;
    logic          br_hit;
    logic [7:0]    err_next;

    // An out-of-range prev only resyncs: the following sample is captured unchecked.
    always_comb begin
        prev_ok  = prev_valid && (32'(prev) < MODULUS);
        expect_q = (32'(prev) == MODULUS - 1) ? '0 : prev + 1'b1;
        legal    = prev_ok && (q_in == expect_q);
        wrap     = legal && (32'(prev) == MODULUS - 1);
        hold0    = prev_ok && !legal && (prev == '0) && (q_in == '0);
        illegal  = prev_ok && !legal && !hold0;
        gw_hit   = (32'(good_wraps) + 32'd1) == LOCK_WRAPS;
        br_hit   = (32'(bad_run) + 32'd1) == UNLOCK_ERRS;
        err_next = (err_cnt == 8'hFF) ? err_cnt : err_cnt + 8'd1;
    end

    assign locked = (state == LOCK);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            seq_err    <= 1'b0;
            tc         <= 1'b0;
            wrap_cnt   <= '0;
            err_cnt    <= '0;
            prev       <= '0;
            prev_valid <= 1'b0;
            good_wraps <= '0;
            bad_run    <= '0;
        end else begin
            seq_err <= 1'b0;
            tc      <= 1'b0;
            if (en) begin
                prev       <= q_in;
                prev_valid <= 1'b1;
                case (state)
                    IDLE: state <= ACQ;
                    ACQ: begin
                        if (illegal) begin
                            seq_err    <= 1'b1;
                            err_cnt    <= err_next;
                            good_wraps <= '0;
                        end else if (hold0) begin
                            good_wraps <= '0;
                        end else if (wrap) begin
                            if (gw_hit) begin
                                state      <= LOCK;
                                good_wraps <= '0;
                                bad_run    <= '0;
                            end else begin
                                good_wraps <= good_wraps + 1'b1;
                            end
                        end
                    end
                    LOCK: begin
                        if (illegal) begin
                            seq_err <= 1'b1;
                            err_cnt <= err_next;
                            if (br_hit) begin
                                state      <= ACQ;
                                good_wraps <= '0;
                                bad_run    <= '0;
                            end else begin
                                bad_run <= bad_run + 1'b1;
                            end
                        end else if (legal) begin
                            bad_run <= '0;
                            if (wrap) begin
                                tc       <= 1'b1;
                                wrap_cnt <= wrap_cnt + 1'b1;
                            end
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_count_seq_monitor.sv
// Directed bench for count_seq_monitor with hand-computed expected outputs.
module tb_count_seq_monitor;

    logic       clk;
    logic       reset;
    logic       en;
    logic [2:0] q_in;
    logic       locked;
    logic       seq_err;
    logic       tc;
    logic [7:0] wrap_cnt;
    logic [7:0] err_cnt;
    logic [1:0] state;

    int n_tests = 0;
    int n_fail  = 0;

    count_seq_monitor #(
        .MODULUS(5), .CW(3), .LOCK_WRAPS(2), .UNLOCK_ERRS(3), .WRAPW(8)
    ) dut (
        .clk(clk), .reset(reset), .en(en), .q_in(q_in),
        .locked(locked), .seq_err(seq_err), .tc(tc),
        .wrap_cnt(wrap_cnt), .err_cnt(err_cnt), .state(state)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic outs(input string tag, input logic [1:0] st, input logic se,
                        input logic t, input int wc, input int ec);
        check({tag, ".state"},    32'(state),    32'(st));
        check({tag, ".locked"},   32'(locked),   32'(st == 2'b10));
        check({tag, ".seq_err"},  32'(seq_err),  32'(se));
        check({tag, ".tc"},       32'(tc),       32'(t));
        check({tag, ".wrap_cnt"}, 32'(wrap_cnt), 32'(wc));
        check({tag, ".err_cnt"},  32'(err_cnt),  32'(ec));
    endtask

    task automatic step(input logic [2:0] q);
        @(negedge clk);
        en   = 1'b1;
        q_in = q;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [2:0] t1 [11] = '{0, 1, 2, 3, 4, 0, 1, 2, 3, 4, 0};
        logic [2:0] cyc [5] = '{1, 2, 3, 4, 0};
        logic [2:0] rl  [8] = '{3, 4, 0, 1, 2, 3, 4, 0};

        reset = 1'b0;
        en    = 1'b0;
        q_in  = '0;
        #3;
        outs("reset", 2'b00, 0, 0, 0, 0);
        @(negedge clk);
        reset = 1'b1;

        // Acquire: two clean wraps lock, no tc while acquiring
        for (int i = 0; i < 11; i++) begin
            step(t1[i]);
            outs($sformatf("acq%0d", i), (i == 10) ? 2'b10 : 2'b01, 0, 0, 0, 0);
        end

        // Locked wrap
        for (int i = 0; i < 5; i++) begin
            step(cyc[i]);
            outs($sformatf("lkwrap%0d", i), 2'b10, 0, i == 4, (i == 4) ? 1 : 0, 0);
        end

        // Single error while locked, then recovery
        step(1); outs("err1_a", 2'b10, 0, 0, 1, 0);
        step(3); outs("err1_b", 2'b10, 1, 0, 1, 1);
        step(4); outs("err1_c", 2'b10, 0, 0, 1, 1);
        step(0); outs("err1_d", 2'b10, 0, 1, 2, 1);

        // Hold at zero keeps lock without error
        step(0); outs("hold0", 2'b10, 0, 0, 2, 1);

        // Three consecutive errors drop lock
        step(2); outs("unlk_a", 2'b10, 1, 0, 2, 2);
        step(4); outs("unlk_b", 2'b10, 1, 0, 2, 3);
        step(1); outs("unlk_c", 2'b01, 1, 0, 2, 4);

        // Out-of-range value resyncs without a second error
        step(2); outs("rs_a", 2'b01, 0, 0, 2, 4);
        step(6); outs("rs_b", 2'b01, 1, 0, 2, 5);
        step(1); outs("rs_c", 2'b01, 0, 0, 2, 5);
        step(2); outs("rs_d", 2'b01, 0, 0, 2, 5);

        // Disabled sampling freezes everything
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            en   = 1'b0;
            q_in = 3'($urandom_range(0, 7));
            @(posedge clk);
            #1;
            outs($sformatf("en0_%0d", i), 2'b01, 0, 0, 2, 5);
        end

        // Relock from prev=2
        for (int i = 0; i < 8; i++) begin
            step(rl[i]);
            outs($sformatf("relock%0d", i), (i == 7) ? 2'b10 : 2'b01, 0, 0, 2, 5);
        end

        // Three more locked wraps -> wrap_cnt=5
        for (int i = 0; i < 15; i++) begin
            step(cyc[i % 5]);
            outs($sformatf("wr%0d", i), 2'b10, 0, (i % 5) == 4, 2 + (i + 1) / 5, 5);
        end

        // Asynchronous reset between edges
        @(negedge clk);
        #2 reset = 1'b0;
        #1;
        outs("async_rst", 2'b00, 0, 0, 0, 0);
        @(negedge clk);
        #1 reset = 1'b1;
        step(0); outs("restart", 2'b01, 0, 0, 0, 0);

        // Error counter saturation with a stuck nonzero value
        for (int n = 1; n <= 256; n++) begin
            step(3);
            if (n == 1 || n == 254 || n == 255 || n == 256)
                outs($sformatf("sat%0d", n), 2'b01, 1, 0, 0, (n > 255) ? 255 : n);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
